// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the VGA 640x480@60 raster generator.
// The visible window bounds double as the clamp range for latched paddle positions.
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam int H_TOTAL_DEF = 800;
    localparam int V_TOTAL_DEF = 525;

    localparam coord_t H_ACT_START = 10'd144;
    localparam coord_t H_ACT_END   = 10'd783;
    localparam coord_t V_ACT_START = 10'd35;
    localparam coord_t V_ACT_END   = 10'd514;

    localparam coord_t POS_RESET   = 10'd275;

    function automatic coord_t clamp_pos(input coord_t pos);
        coord_t res;
        res = pos;
        if (pos < V_ACT_START) begin
            res = V_ACT_START;
        end else if (pos > V_ACT_END) begin
            res = V_ACT_END;
        end
        return res;
    endfunction

endpackage

// File: rtl/vga_pix_en_div.sv
// Clock divider that produces a registered one-clk pixel strobe every CLK_DIV clocks.
// The strobe is aligned so that it is high in the cycle where div_cnt == CLK_DIV-1.
module vga_pix_en_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic pix_en_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt_q;
    logic [CW-1:0] div_cnt_d;
    logic          pix_en_q;

    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    end

    // Decoding the next count keeps the strobe coincident with the last divider phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            pix_en_q  <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            pix_en_q  <= (div_cnt_d == DIV_LAST);
        end
    end

    assign pix_en_o = pix_en_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster counters with frame-synchronous paddle position buffering.
// Define VGA_POS_CLAMP_EN to clamp latched positions to the visible line range.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int H_TOTAL = H_TOTAL_DEF,
    parameter int V_TOTAL = V_TOTAL_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] team1_ver_req,
    input  logic [9:0] team2_ver_req,
    output logic [9:0] current_pixel,
    output logic [9:0] current_line,
    output logic [9:0] team1_ver_pos,
    output logic [9:0] team2_ver_pos,
    output logic       pix_en,
    output logic       frame_tick,
    output logic       in_active
);

    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

    coord_t pixel_q, pixel_d;
    coord_t line_q,  line_d;
    coord_t pos1_q,  pos1_d;
    coord_t pos2_q,  pos2_d;
    coord_t pos1_latch, pos2_latch;
    logic   pix_en_w;
    logic   at_h_end, at_v_end;

    vga_pix_en_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .pix_en_o (pix_en_w)
    );

    assign at_h_end   = (pixel_q == H_LAST);
    assign at_v_end   = (line_q == V_LAST);
    assign frame_tick = pix_en_w & at_h_end & at_v_end;

`ifdef VGA_POS_CLAMP_EN
    assign pos1_latch = clamp_pos(team1_ver_req);
    assign pos2_latch = clamp_pos(team2_ver_req);
`else
    assign pos1_latch = team1_ver_req;
    assign pos2_latch = team2_ver_req;
`endif

    always_comb begin
        pixel_d = pixel_q;
        line_d  = line_q;
        pos1_d  = pos1_q;
        pos2_d  = pos2_q;
        if (pix_en_w) begin
            if (at_h_end) begin
                pixel_d = '0;
                line_d  = at_v_end ? '0 : line_q + 10'd1;
            end else begin
                pixel_d = pixel_q + 10'd1;
            end
        end
        // Positions only move on the frame boundary so a paddle never tears mid-frame.
        if (frame_tick) begin
            pos1_d = pos1_latch;
            pos2_d = pos2_latch;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_q <= '0;
            line_q  <= '0;
            pos1_q  <= POS_RESET;
            pos2_q  <= POS_RESET;
        end else begin
            pixel_q <= pixel_d;
            line_q  <= line_d;
            pos1_q  <= pos1_d;
            pos2_q  <= pos2_d;
        end
    end

    assign in_active = (pixel_q >= H_ACT_START) && (pixel_q <= H_ACT_END) &&
                       (line_q >= V_ACT_START) && (line_q <= V_ACT_END);

    assign current_pixel = pixel_q;
    assign current_line  = line_q;
    assign team1_ver_pos = pos1_q;
    assign team2_ver_pos = pos2_q;
    assign pix_en        = pix_en_w;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a short-frame instance for frame/position timing
// and a CLK_DIV=1 instance tall enough to reach the visible window.
module tb_vga_timing_gen;

    localparam int CYC_FRAME = 800 * 8 * 2;

`ifdef VGA_POS_CLAMP_EN
    localparam int EXP_LO = 35;
    localparam int EXP_HI = 514;
`else
    localparam int EXP_LO = 10;
    localparam int EXP_HI = 600;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] t1_req = 10'd275;
    logic [9:0] t2_req = 10'd500;
    logic [9:0] pixel, line, pos1, pos2;
    logic       pix_en, frame_tick, in_active;

    logic [9:0] act_req = 10'd275;
    logic [9:0] act_pixel, act_line, act_pos1, act_pos2;
    logic       act_pix_en, act_frame_tick, act_in_active;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pe_cnt   = 0;
    int ft_cnt   = 0;
    int tick1_cyc;
    int rel_cyc;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CLK_DIV (2),
        .H_TOTAL (800),
        .V_TOTAL (8)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .team1_ver_req (t1_req),
        .team2_ver_req (t2_req),
        .current_pixel (pixel),
        .current_line  (line),
        .team1_ver_pos (pos1),
        .team2_ver_pos (pos2),
        .pix_en        (pix_en),
        .frame_tick    (frame_tick),
        .in_active     (in_active)
    );

    vga_timing_gen #(
        .CLK_DIV (1),
        .H_TOTAL (800),
        .V_TOTAL (40)
    ) u_act (
        .clk           (clk),
        .rst           (rst),
        .team1_ver_req (act_req),
        .team2_ver_req (act_req),
        .current_pixel (act_pixel),
        .current_line  (act_line),
        .team1_ver_pos (act_pos1),
        .team2_ver_pos (act_pos2),
        .pix_en        (act_pix_en),
        .frame_tick    (act_frame_tick),
        .in_active     (act_in_active)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (pix_en) pe_cnt++;
        if (frame_tick) ft_cnt++;
    endtask

    // Advance to the pix_en cycle of the main instance's (px, ln).
    task automatic wait_at(input int px, input int ln, input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(pixel == 10'(px) && line == 10'(ln) && pix_en) && n < 20000);
        if (!(pixel == 10'(px) && line == 10'(ln) && pix_en))
            check_eq({"timeout_", tag}, 0, 1);
    endtask

    task automatic wait_act(input int px, input int ln, input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(act_pixel == 10'(px) && act_line == 10'(ln)) && n < 40000);
        if (!(act_pixel == 10'(px) && act_line == 10'(ln)))
            check_eq({"timeout_", tag}, 0, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_pixel", int'(pixel), 0);
        check_eq("rst_line", int'(line), 0);
        check_eq("rst_pos1", int'(pos1), 275);
        check_eq("rst_pos2", int'(pos2), 275);
        check_eq("rst_pix_en", int'(pix_en), 0);
        check_eq("rst_frame_tick", int'(frame_tick), 0);
        check_eq("rst_in_active", int'(in_active), 0);

        rst = 1'b0;
        #1;
        check_eq("c0_pix_en", int'(pix_en), 0);
        tick();
        check_eq("c1_pix_en", int'(pix_en), 1);
        check_eq("c1_pixel", int'(pixel), 0);
        check_eq("c1_act_pix_en", int'(act_pix_en), 1);
        tick();
        check_eq("c2_pix_en", int'(pix_en), 0);
        check_eq("c2_pixel", int'(pixel), 1);

        wait_at(0, 5, "l5_start");
        t1_req = 10'd100;
        wait_at(799, 5, "l5_end");
        check_eq("l5_end_frame_tick", int'(frame_tick), 0);
        check_eq("l5_end_pos1", int'(pos1), 275);
        tick();
        tick();
        check_eq("l6_pixel", int'(pixel), 0);
        check_eq("l6_line", int'(line), 6);

        wait_at(799, 7, "f1_end");
        check_eq("f1_frame_tick", int'(frame_tick), 1);
        check_eq("f1_end_pos1", int'(pos1), 275);
        check_eq("f1_end_pos2", int'(pos2), 275);
        check_eq("f1_in_active", int'(in_active), 0);
        tick1_cyc = cyc;
        tick();
        check_eq("f2_pixel", int'(pixel), 0);
        check_eq("f2_line", int'(line), 0);
        check_eq("f2_pos1", int'(pos1), 100);
        check_eq("f2_pos2", int'(pos2), 500);
        pe_cnt = 0;
        ft_cnt = 0;

        wait_at(5, 0, "f2_p5");
        t1_req = 10'd300;
        wait_at(799, 3, "f2_l3");
        check_eq("f2_mid_pos1", int'(pos1), 100);
        t1_req = 10'd10;
        t2_req = 10'd600;
        wait_at(799, 7, "f2_end");
        check_eq("f2_end_pos1", int'(pos1), 100);
        check_eq("frame_pix_en_count", pe_cnt, 800 * 8);
        check_eq("frame_tick_count", ft_cnt, 1);
        check_eq("frame_period", cyc - tick1_cyc, CYC_FRAME);
        tick();
        check_eq("f3_pos1_lo", int'(pos1), EXP_LO);
        check_eq("f3_pos2_hi", int'(pos2), EXP_HI);

        wait_act(200, 34, "act_l34");
        check_eq("act_200_34", int'(act_in_active), 0);
        wait_act(143, 35, "act_143");
        check_eq("act_143_35", int'(act_in_active), 0);
        tick();
        check_eq("act_144_px", int'(act_pixel), 144);
        check_eq("act_144_35", int'(act_in_active), 1);
        wait_act(783, 35, "act_783");
        check_eq("act_783_35", int'(act_in_active), 1);
        tick();
        check_eq("act_784_35", int'(act_in_active), 0);

        wait_at(0, 3, "f3_l3");
        rst = 1'b1;
        #1;
        check_eq("mid_rst_pixel", int'(pixel), 0);
        check_eq("mid_rst_line", int'(line), 0);
        check_eq("mid_rst_pos1", int'(pos1), 275);
        check_eq("mid_rst_pos2", int'(pos2), 275);
        repeat (3) tick();
        check_eq("mid_rst_hold_pix_en", int'(pix_en), 0);
        check_eq("mid_rst_hold_line", int'(line), 0);
        rst = 1'b0;
        rel_cyc = cyc;
        wait_at(799, 7, "restart_end");
        check_eq("restart_frame_cycles", cyc - rel_cyc, CYC_FRAME - 1);
        check_eq("restart_frame_tick", int'(frame_tick), 1);
        check_eq("restart_pos1", int'(pos1), 275);
        tick();
        check_eq("restart_wrap_line", int'(line), 0);
        check_eq("restart_pos1_latched", int'(pos1), EXP_LO);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Free-running VGA 640x480@60 raster generator that produces the `current_pixel`/`current_line` counters consumed by `vga_controller`. It divides the system clock down to a pixel-rate enable. It also double-buffers the two team vertical positions so they change only at frame boundaries, which keeps the paddles from tearing mid-frame. It sits between the game logic and `vga_controller`.

## Interface
Parameters:
- `CLK_DIV`, 2: system clocks per pixel. Legal range 1..16. With a 50 MHz clock this gives a 25 MHz pixel rate.
- `H_TOTAL`, 800: pixels per line, counting from 0.
- `V_TOTAL`, 525: lines per frame, counting from 0.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `team1_ver_req`  in  10  requested team 1 vertical position (line number), sampled at frame end.
- `team2_ver_req`  in  10  requested team 2 vertical position, sampled at frame end.
- `current_pixel`  out  10  horizontal counter, 0..H_TOTAL-1.
- `current_line`  out  10  vertical counter, 0..V_TOTAL-1.
- `team1_ver_pos`  out  10  frame-stable team 1 position.
- `team2_ver_pos`  out  10  frame-stable team 2 position.
- `pix_en`  out  1  one-clk pixel strobe.
- `frame_tick`  out  1  one-clk pulse on the last pixel of a frame.
- `in_active`  out  1  high while the counters are inside the visible window.

## Operation
- Divider:
  - `div_cnt` counts 0..CLK_DIV-1 and wraps.
  - `pix_en` is registered. It is high for exactly one clk per CLK_DIV clocks, in the cycle where `div_cnt == CLK_DIV-1`.
  - With CLK_DIV=1, `pix_en` is constantly high after reset.
- Counters advance only at a clk edge where `pix_en=1`:
  - `current_pixel` increments. At H_TOTAL-1 it wraps to 0 and `current_line` increments.
  - At (H_TOTAL-1, V_TOTAL-1) both counters wrap to 0.
- `frame_tick` is high when `pix_en=1` and the counters are at (H_TOTAL-1, V_TOTAL-1).
- Position buffering:
  - At the edge that ends a `frame_tick` cycle, `teamN_ver_pos <= teamN_ver_req`.
  - The requests are ignored at all other times, so the outputs are constant for an entire frame.
- `in_active` is a combinational decode of the registered counters: 143 < pixel < 784 and 34 < line < 515. This is the same window as the consumer's colour logic.
- Sync pulses are not generated here. The consumer derives them from the counters (hsync low for pixels 0..95, vsync low for lines 0..1).
- All arithmetic is unsigned 10-bit. The counters never exceed H_TOTAL-1 / V_TOTAL-1.

## Timing
- Reset values:
  - `current_pixel=0`, `current_line=0`, `div_cnt=0`.
  - `pix_en=0`, `frame_tick=0`.
  - `team1_ver_pos=team2_ver_pos=275` (visible centre).
  - `in_active=0`, which follows from counters at 0.
- After `rst` falls, the first `pix_en` occurs in clk cycle CLK_DIV-1, counting the first post-reset cycle as 0.
- Each counter value is held for exactly CLK_DIV clks.
- Frame period is H_TOTAL·V_TOTAL·CLK_DIV clks (840000 at defaults). `frame_tick` fires once per period.
- Position latency:
  - A request becomes visible on the outputs in the same cycle the counters become (0,0).
  - This is between 1 and one full frame after the request changes.
- Simultaneous request change and `frame_tick`: the value present in the `frame_tick` cycle is captured.
- `rst` asserted mid-frame: all state returns to reset values immediately (asynchronous). No partial frame is resumed.

## Configuration
- `VGA_POS_CLAMP_EN` defined: latched positions are clamped to the visible line range [35, 514]. Requests below 35 latch as 35 and requests above 514 latch as 514.
- Not defined: requests latch unmodified, with the full 0..1023 range passed through.

## Structure
- Package `vga_timing_pkg`:
  - Constants H_TOTAL_DEF=800, V_TOTAL_DEF=525.
  - H_ACT_START=144, H_ACT_END=783, V_ACT_START=35, V_ACT_END=514.
  - POS_RESET=275, and a 10-bit `coord_t` typedef.
- Sub-module `vga_pix_en_div` holds `div_cnt` and the registered `pix_en`, parameterised by CLK_DIV.
- The top level holds the counters, the frame detect, the position registers and the optional clamp.

## Test plan
- Reset, then release, CLK_DIV=2 → `pix_en` first high in cycle 1. All outputs hold their reset values (pos=275) until then.
- Run to pixel 799 on line 10 → next `pix_en` edge gives pixel=0, line=11. `frame_tick` stays 0.
- Run a full frame → exactly 420000 `pix_en` pulses and exactly one `frame_tick` (at 799,524). The counters are then (0,0) and the next `frame_tick` comes 840000 clks later.
- Set `team1_ver_req=100` at line 200 → `team1_ver_pos` stays 275 until counters reach (0,0), then reads 100. Changing the request to 300 at line 0 pixel 5 leaves 100 for the whole frame.
- With `VGA_POS_CLAMP_EN` defined, request 10 → latches 35 and request 600 → latches 514. Without the macro, the same requests latch 10 and 600.
- Assert `rst` at line 300 for 3 clks → counters are 0 and positions are 275 during reset. Frame timing restarts from (0,0) on release.
